gcd_lcm_unit: RTL

Multicycle unsigned GCD/LCM execution unit of the coprocessor.
- Consumes the two register-file read operands (RD1/RD2 values) plus the destination register index.
- Produces a 32-bit result and a one-cycle write-back strobe that drives the register-file RegWrite/A3/WD inputs.
- Sits directly downstream of the register file and feeds it back on completion.

---
 rtl/gcd_lcm_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/gcd_lcm_unit.sv
// Multicycle unsigned GCD/LCM execution unit: subtractive Euclid, then a restoring
// divide (a / g) and a shift-add multiply (q * b) for LCM, writing back through done/result/rd_out.
module gcd_lcm_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [AW-1:0]    rd_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GCD  = 3'd1,
    S_DIV  = 3'd2,
    S_MUL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_a_orig;
  logic [WIDTH-1:0] r_b_orig;
  logic             r_op;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_prod;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [AW-1:0]    r_rd_out;
  logic             r_busy;
  logic             r_done;

  logic             w_zero_op;
  logic             w_cnt_last;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_prod_next;

  assign w_zero_op  = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
  assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));

  // One restoring-division step: the remainder after a successful subtract is below g,
  // so the low WIDTH bits of the difference are exact.
  always_comb begin
    w_trial     = {r_rem, r_q[WIDTH-1]};
    w_qbit      = (w_trial >= {1'b0, r_g});
    w_rem_sub   = w_trial[WIDTH-1:0] - r_g;
    w_rem_next  = w_qbit ? w_rem_sub : w_trial[WIDTH-1:0];
    w_q_next    = {r_q[WIDTH-2:0], w_qbit};
    w_prod_next = r_q[0] ? (r_prod + r_mcand) : r_prod;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = w_zero_op ? S_DONE : S_GCD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_GCD: begin
        if (r_x == r_y) begin
          w_next_state = r_op ? S_DIV : S_DONE;
        end else begin
          w_next_state = S_GCD;
        end
      end
      S_DIV: begin
        if (w_cnt_last) begin
          w_next_state = S_MUL;
        end else begin
          w_next_state = S_DIV;
        end
      end
      S_MUL: begin
        if (w_cnt_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_MUL;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register plus registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Datapath: operand latch, Euclid steps, divider, multiplier and result write-back
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x      <= {WIDTH{1'b0}};
      r_y      <= {WIDTH{1'b0}};
      r_a_orig <= {WIDTH{1'b0}};
      r_b_orig <= {WIDTH{1'b0}};
      r_op     <= 1'b0;
      r_g      <= {WIDTH{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_q      <= {WIDTH{1'b0}};
      r_mcand  <= {WIDTH{1'b0}};
      r_prod   <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_rd_out <= {AW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x      <= a;
            r_y      <= b;
            r_a_orig <= a;
            r_b_orig <= b;
            r_op     <= op;
            r_rd_out <= rd_in;
            if (w_zero_op) begin
              r_result <= op ? {WIDTH{1'b0}} : (a | b);
            end
          end
        end
        S_GCD: begin
          if (r_x > r_y) begin
            r_x <= r_x - r_y;
          end else if (r_y > r_x) begin
            r_y <= r_y - r_x;
          end else begin
            r_g   <= r_x;
            r_rem <= {WIDTH{1'b0}};
            r_q   <= r_a_orig;
            r_cnt <= {CW{1'b0}};
            if (!r_op) begin
              r_result <= r_x;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= w_cnt_last ? {CW{1'b0}} : (r_cnt + CW'(1));
          if (w_cnt_last) begin
            r_mcand <= r_b_orig;
            r_prod  <= {WIDTH{1'b0}};
          end
        end
        S_MUL: begin
          r_prod  <= w_prod_next;
          r_q     <= {1'b0, r_q[WIDTH-1:1]};
          r_mcand <= {r_mcand[WIDTH-2:0], 1'b0};
          r_cnt   <= w_cnt_last ? {CW{1'b0}} : (r_cnt + CW'(1));
          if (w_cnt_last) begin
            r_result <= w_prod_next;
          end
        end
        S_DONE: begin
          r_cnt <= {CW{1'b0}};
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule
